// File: rtl/ext_sd_spi_master_pkg.sv
// Shared types and constants for the SD-card SPI byte engine.
package ext_sd_pkg;

  typedef enum logic [1:0] {SPI_IDLE, SPI_LO, SPI_HI, SPI_DONE} spi_state_t;

  localparam logic [7:0] SPI_FILL_BYTE    = 8'hFF;
  localparam int         SPI_SLOW_DIV_DEF = 26;
  localparam int         SPI_FAST_DIV_DEF = 0;

  // Half-period counter width; at least one bit so a zero divider still builds.
  function automatic int div_w(input int d);
    return (d < 1) ? 1 : $clog2(d + 1);
  endfunction

endpackage

// File: rtl/ext_sd_spi_master_if.sv
// Mapper-side request/response signals plus the physical SD SPI pins.
interface ext_sd_spi_master_if;
  logic       tx;
  logic       rx;
  logic [7:0] data_to_SD;
  logic       cs_req;
  logic       fast;
  logic [7:0] data_from_SD;
  logic       busy;
  logic       sd_sclk;
  logic       sd_mosi;
  logic       sd_miso;
  logic       sd_cs_n;

  modport master (
    output tx, rx, data_to_SD, cs_req, fast,
    input  data_from_SD, busy
  );

  modport slave (
    input  tx, rx, data_to_SD, cs_req, fast, sd_miso,
    output data_from_SD, busy, sd_sclk, sd_mosi, sd_cs_n
  );
endinterface

// File: rtl/ext_sd_spi_master_clkdiv.sv
// Reloadable SCK half-period counter; o_tick marks the last cycle of a half-period.
module sd_spi_clkdiv #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic [W-1:0] i_div,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;

  assign o_tick = (r_cnt == i_div);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             r_cnt <= '0;
    else if (i_clr || o_tick) r_cnt <= '0;
    else                      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/ext_sd_spi_master.sv
// SPI mode-0 byte engine for the ESE-RAM mapper SD port, MSB first.
// Optional ESE_SD_BYTE_CNT_EN adds a wrapping 16-bit completed-byte counter output.
module ext_sd_spi_master
  import ext_sd_pkg::*;
#(
  parameter int SLOW_DIV = SPI_SLOW_DIV_DEF,
  parameter int FAST_DIV = SPI_FAST_DIV_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ext_sd_spi_master_if.slave   bus
`ifdef ESE_SD_BYTE_CNT_EN
  ,
  output logic [15:0]          byte_cnt
`endif
);

  localparam int CW = div_w(SLOW_DIV);

  spi_state_t  r_state;
  logic [CW-1:0] r_div;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_shreg;   // bits still to send; bit 7 lives in r_mosi
  logic [7:0]  r_rxreg;
  logic [7:0]  r_dout;
  logic        r_sclk, r_mosi, r_cs_n, r_busy;
  logic        w_tick;
  logic [7:0]  w_load;

  assign w_load = bus.tx ? bus.data_to_SD : SPI_FILL_BYTE;

  sd_spi_clkdiv #(.W(CW)) u_clkdiv (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (r_state == SPI_IDLE),
    .i_div   (r_div),
    .o_tick  (w_tick)
  );

`ifdef ESE_SD_BYTE_CNT_EN
  logic [15:0] r_byte_cnt;
  assign byte_cnt = r_byte_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  r_byte_cnt <= '0;
    else if (r_state == SPI_DONE)  r_byte_cnt <= r_byte_cnt + 16'd1;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= SPI_IDLE;
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_rxreg   <= '0;
      r_dout    <= SPI_FILL_BYTE;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b1;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      // Card select is a free-running level; it never aborts a byte.
      r_cs_n <= ~bus.cs_req;
      case (r_state)
        SPI_IDLE: if (bus.tx || bus.rx) begin
          r_shreg   <= w_load[6:0];
          r_mosi    <= w_load[7];
          r_div     <= bus.fast ? CW'(FAST_DIV) : CW'(SLOW_DIV);
          r_bit_cnt <= '0;
          r_busy    <= 1'b1;
          r_state   <= SPI_LO;
        end
        SPI_LO: if (w_tick) begin
          r_sclk  <= 1'b1;
          r_rxreg <= {r_rxreg[6:0], bus.sd_miso};
          r_state <= SPI_HI;
        end
        SPI_HI: if (w_tick) begin
          r_sclk <= 1'b0;
          if (r_bit_cnt == 3'd7) begin
            r_state <= SPI_DONE;
          end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_mosi    <= r_shreg[6];
            r_shreg   <= {r_shreg[5:0], 1'b0};
            r_state   <= SPI_LO;
          end
        end
        SPI_DONE: begin
          r_dout  <= r_rxreg;
          r_busy  <= 1'b0;
          r_mosi  <= 1'b1;
          r_state <= SPI_IDLE;
        end
        default: r_state <= SPI_IDLE;
      endcase
    end
  end

  assign bus.data_from_SD = r_dout;
  assign bus.busy         = r_busy;
  assign bus.sd_sclk      = r_sclk;
  assign bus.sd_mosi      = r_mosi;
  assign bus.sd_cs_n      = r_cs_n;

endmodule

// File: tb/tb_ext_sd_spi_master.sv
// Directed bench for ext_sd_spi_master: loopback / pattern MISO model, SCK edge monitor.
module tb_ext_sd_spi_master;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  ext_sd_spi_master_if bus();
`ifdef ESE_SD_BYTE_CNT_EN
  logic [15:0] byte_cnt;
`endif

  ext_sd_spi_master #(.SLOW_DIV(26), .FAST_DIV(0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
`ifdef ESE_SD_BYTE_CNT_EN
    ,
    .byte_cnt(byte_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Card model: either echo MOSI or shift out pat MSB first, advancing after each SCK rise.
  logic       loop = 1'b1;
  logic [7:0] pat  = 8'h00;
  int         rises = 0;
  logic       miso_m;
  always_comb miso_m = loop ? bus.sd_mosi : pat[~rises[2:0]];
  assign bus.sd_miso = miso_m;

  // SCK monitor sampled mid-cycle: rise count, MOSI seen at rises, last half-period lengths.
  logic       prev_sclk = 1'b0;
  logic [7:0] mosi_sr = 8'h00;
  int busy_cyc = 0, run = 0, lo_len = 0, hi_len = 0;
  always @(negedge clk) begin
    if (bus.busy) busy_cyc++;
    if (bus.sd_sclk && !prev_sclk) begin
      rises++;
      mosi_sr = {mosi_sr[6:0], bus.sd_mosi};
      lo_len  = run;
      run     = 1;
    end else if (!bus.sd_sclk && prev_sclk) begin
      hi_len = run;
      run    = 1;
    end else begin
      run++;
    end
    prev_sclk = bus.sd_sclk;
  end

  // One request; optional stray tx pulse inj cycles into the byte. Returns busy cycles and SCK rises.
  task automatic xfer(input logic t, input logic r, input logic [7:0] d, input logic f,
                      input int inj, output int bcyc, output int nr);
    int b0, r0;
    bit done;
    r0 = rises;
    @(posedge clk); #1;
    bus.tx = t; bus.rx = r; bus.data_to_SD = d; bus.fast = f;
    @(posedge clk); #1;
    bus.tx = 1'b0; bus.rx = 1'b0;
    b0 = busy_cyc;
    chk("busy_rise", {31'd0, bus.busy}, 32'd1);
    if (inj > 0) begin
      repeat (inj) @(posedge clk);
      #1; bus.tx = 1'b1; bus.data_to_SD = 8'hFF;
      @(posedge clk); #1; bus.tx = 1'b0;
    end
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (!bus.busy) done = 1'b1;
    end
    if (!done) chk("busy_timeout", {31'd0, bus.busy}, 32'd0);
    bcyc = busy_cyc - b0;
    nr   = rises - r0;
  endtask

  int bc, nr;

  initial begin
    bus.tx = 1'b0; bus.rx = 1'b0; bus.data_to_SD = 8'h00; bus.cs_req = 1'b0; bus.fast = 1'b1;
    #2 reset_n = 1'b0;
    #10;
    chk("rst_sclk", {31'd0, bus.sd_sclk}, 32'd0);
    chk("rst_mosi", {31'd0, bus.sd_mosi}, 32'd1);
    chk("rst_csn",  {31'd0, bus.sd_cs_n}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy},    32'd0);
    chk("rst_dout", {24'd0, bus.data_from_SD}, 32'hFF);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Loopback tx A5 at fast speed
    xfer(1'b1, 1'b0, 8'hA5, 1'b1, 0, bc, nr);
    chk("lb_busy",  bc, 17);
    chk("lb_rises", nr, 8);
    chk("lb_mosi",  {24'd0, mosi_sr}, 32'hA5);
    chk("lb_dout",  {24'd0, bus.data_from_SD}, 32'hA5);

    // rx with card pattern 3C; MOSI must stay high
    loop = 1'b0; pat = 8'h3C;
    xfer(1'b0, 1'b1, 8'h00, 1'b1, 0, bc, nr);
    chk("rx_rises", nr, 8);
    chk("rx_mosi",  {24'd0, mosi_sr}, 32'hFF);
    chk("rx_dout",  {24'd0, bus.data_from_SD}, 32'h3C);
    loop = 1'b1;

    // Slow speed: 27-cycle half periods, 433 busy cycles
    xfer(1'b1, 1'b0, 8'h96, 1'b0, 0, bc, nr);
    chk("slow_busy", bc, 433);
    chk("slow_hi",   hi_len, 27);
    chk("slow_lo",   lo_len, 27);
    chk("slow_dout", {24'd0, bus.data_from_SD}, 32'h96);

    // tx+rx together (tx wins), plus an ignored tx mid-byte
    xfer(1'b1, 1'b1, 8'h40, 1'b1, 3, bc, nr);
    chk("both_mosi",  {24'd0, mosi_sr}, 32'h40);
    chk("both_busy",  bc, 17);
    chk("both_dout",  {24'd0, bus.data_from_SD}, 32'h40);
    nr = rises;
    repeat (6) @(negedge clk);
    chk("ign_rises", rises - nr, 0);
    chk("hold_dout", {24'd0, bus.data_from_SD}, 32'h40);

    // Chip select follows cs_req one cycle later, even mid-byte
    @(posedge clk); #1 bus.cs_req = 1'b1;
    @(negedge clk); chk("cs_pre", {31'd0, bus.sd_cs_n}, 32'd1);
    @(posedge clk); #1 chk("cs_on", {31'd0, bus.sd_cs_n}, 32'd0);
    fork
      xfer(1'b1, 1'b0, 8'h5A, 1'b1, 0, bc, nr);
      begin
        repeat (6) @(posedge clk);
        #1 bus.cs_req = 1'b0;
        @(negedge clk); chk("cs_mid_pre", {31'd0, bus.sd_cs_n}, 32'd0);
        @(posedge clk); #1 chk("cs_mid_off", {31'd0, bus.sd_cs_n}, 32'd1);
      end
    join
    chk("cs_busy", bc, 17);
    chk("cs_dout", {24'd0, bus.data_from_SD}, 32'h5A);

    // Async reset mid-byte while SCK high and MOSI low
    bus.cs_req = 1'b1;
    @(posedge clk); #1 bus.tx = 1'b1; bus.data_to_SD = 8'h00; bus.fast = 1'b0;
    @(posedge clk); #1 bus.tx = 1'b0;
    repeat (40) @(posedge clk);
    #3 chk("mid_sclk", {31'd0, bus.sd_sclk}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mrst_sclk", {31'd0, bus.sd_sclk}, 32'd0);
    chk("mrst_mosi", {31'd0, bus.sd_mosi}, 32'd1);
    chk("mrst_csn",  {31'd0, bus.sd_cs_n}, 32'd1);
    chk("mrst_busy", {31'd0, bus.busy},    32'd0);
    chk("mrst_dout", {24'd0, bus.data_from_SD}, 32'hFF);
    bus.cs_req = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Three bytes after reset
    xfer(1'b1, 1'b0, 8'h01, 1'b1, 0, bc, nr);
    xfer(1'b1, 1'b0, 8'h80, 1'b1, 0, bc, nr);
    chk("b2_dout", {24'd0, bus.data_from_SD}, 32'h80);
    xfer(1'b0, 1'b1, 8'h00, 1'b1, 0, bc, nr);
    chk("b3_dout", {24'd0, bus.data_from_SD}, 32'hFF);
    chk("b3_rises", nr, 8);
`ifdef ESE_SD_BYTE_CNT_EN
    chk("byte_cnt", {16'd0, byte_cnt}, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
